// File: rtl/audio_period_detector.sv
// Tone period detector: classifies accepted ADC samples with hysteresis and
// measures the distance in accepted samples between successive LOW->HIGH edges.
module audio_period_detector #(
    parameter int unsigned W    = 24,
    parameter int unsigned HYST = 2048,
    parameter int unsigned CW   = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          read_ready,
    input  logic [W-1:0]  readdata,
    output logic          read,
    output logic [CW-1:0] period,
    output logic          period_valid,
    output logic          tone_present,
    output logic          level
);

    typedef enum logic [1:0] {
        StUnknown,
        StLow,
        StHigh
    } state_e;

    localparam logic signed [W-1:0] HystPos = $signed(W'(HYST));
    localparam logic signed [W-1:0] HystNeg = -HystPos;
    localparam logic [CW-1:0]       CntMax  = '1;

    state_e           state_q, state_d;
    logic             armed_q, armed_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             tone_q, tone_d;
    logic             rising;
    logic signed [W-1:0] sample;

    assign read   = en & read_ready;
    assign sample = $signed(readdata);

    always_comb begin
        state_d        = state_q;
        armed_d        = armed_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        tone_d         = tone_q;
        rising         = 1'b0;

        if (read) begin
            if (sample > HystPos) begin
                state_d = StHigh;
            end else if (sample < HystNeg) begin
                state_d = StLow;
            end

            // UNKNOWN->HIGH is deliberately not an edge: first lock needs a real LOW.
            rising = (state_q == StLow) && (state_d == StHigh);

            if (rising) begin
                cnt_d   = CW'(1);
                armed_d = 1'b1;
                if (armed_q) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    tone_d         = 1'b1;
                end
            end else if (armed_q) begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Too long since the last edge: drop lock, next edge only re-arms.
                if (cnt_d == CntMax) begin
                    armed_d = 1'b0;
                    tone_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StUnknown;
            armed_q        <= 1'b0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            tone_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            armed_q        <= armed_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            tone_q         <= tone_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign tone_present = tone_q;
    assign level        = (state_q == StHigh);

endmodule

// File: tb/tb_audio_period_detector.sv
// Scoreboard bench: two detectors (CW=20 and CW=4) share stimulus; a rising-edge
// index model predicts each accepted sample's outputs.
module tb_audio_period_detector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        read_ready = 1'b0;
    logic [23:0] readdata = '0;

    logic        read0, pv0, tone0, level0;
    logic [19:0] period0;
    logic        read1, pv1, tone1, level1;
    logic [3:0]  period1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    audio_period_detector #(.W(24), .HYST(2048), .CW(20)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .read_ready   (read_ready),
        .readdata     (readdata),
        .read         (read0),
        .period       (period0),
        .period_valid (pv0),
        .tone_present (tone0),
        .level        (level0)
    );

    audio_period_detector #(.W(24), .HYST(2048), .CW(4)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .read_ready   (read_ready),
        .readdata     (readdata),
        .read         (read1),
        .period       (period1),
        .period_valid (pv1),
        .tone_present (tone1),
        .level        (level1)
    );

    typedef struct packed {
        logic        lvl;
        logic        tone;
        logic        pv;
        logic [19:0] per;
    } exp_t;

    typedef struct {
        int          lvl;        // 0 unknown, 1 low, 2 high
        bit          armed;
        int          last_rise;
        int          idx;
        bit          tone;
        int unsigned period;
        int          maxcnt;
    } model_t;

    exp_t   q0[$];
    exp_t   q1[$];
    model_t m[2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m[d].lvl = 0;
            m[d].armed = 1'b0;
            m[d].last_rise = 0;
            m[d].idx = 0;
            m[d].tone = 1'b0;
            m[d].period = 0;
        end
        m[0].maxcnt = (1 << 20) - 1;
        m[1].maxcnt = 15;
    endfunction

    // Period = index distance between rising edges; lock is lost once the
    // running distance reaches the counter's maximum.
    function automatic void model_step(input int d, input logic [23:0] s);
        model_t mm;
        int     sv;
        int     prev;
        bit     pv;
        exp_t   e;
        mm = m[d];
        sv = int'($signed(s));
        prev = mm.lvl;
        pv = 1'b0;
        if (sv > 2048) mm.lvl = 2;
        else if (sv < -2048) mm.lvl = 1;
        if (prev == 1 && mm.lvl == 2) begin
            if (mm.armed) begin
                mm.period = int'(mm.idx - mm.last_rise);
                pv = 1'b1;
                mm.tone = 1'b1;
            end
            mm.armed = 1'b1;
            mm.last_rise = mm.idx;
        end else if (mm.armed && (mm.idx - mm.last_rise + 1 >= mm.maxcnt)) begin
            mm.armed = 1'b0;
            mm.tone = 1'b0;
        end
        mm.idx++;
        m[d] = mm;
        e.lvl = (mm.lvl == 2);
        e.tone = mm.tone;
        e.pv = pv;
        e.per = 20'(mm.period);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic [23:0] s, input logic rr, input logic e);
        readdata = s;
        read_ready = rr;
        en = e;
        if (e && rr) begin
            model_step(0, s);
            model_step(1, s);
        end
        #1;
        check("read_strobe", {30'b0, read1, read0}, {30'b0, e & rr, e & rr});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic e);
        reset = 1'b1;
        en = e;
        read_ready = 1'b1;
        readdata = 24'h7FFFFF;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("reset_outs0", {9'b0, level0, tone0, pv0, period0}, 32'b0);
        check("reset_outs1", {25'b0, level1, tone1, pv1, period1}, 32'b0);
    endtask

    function automatic logic [23:0] noise_val();
        case ($urandom_range(0, 3))
            0: return 24'(1000);
            1: return 24'(-1000);
            2: return 24'(2048);
            default: return 24'(-2048);
        endcase
    endfunction

    task automatic gap(input bit gappy);
        if (gappy) begin
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 1) == 0) drive(24'($urandom), 1'b0, 1'b1);
                else drive(24'($urandom), $urandom_range(0, 1) == 1, 1'b0);
            end
        end
    endtask

    task automatic sq(input int hh, input int hl, input int reps, input bit noisy,
                      input bit gappy);
        logic [23:0] v;
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hh; i++) begin
                v = (noisy && i > 0 && $urandom_range(0, 1) == 1) ? noise_val() : 24'h7FFFFF;
                gap(gappy);
                drive(v, 1'b1, 1'b1);
            end
            for (int i = 0; i < hl; i++) begin
                v = (noisy && i > 0 && $urandom_range(0, 1) == 1) ? noise_val() : 24'h800000;
                gap(gappy);
                drive(v, 1'b1, 1'b1);
            end
        end
    endtask

    // Monitor: every accepted cycle pops one prediction per DUT.
    initial begin : monitor
        logic acc;
        exp_t e;
        forever begin
            @(posedge clk);
            acc = read0 && !reset;
            #2;
            if (acc) begin
                if (q0.size() == 0) begin
                    check("dut0_unexpected_accept", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    check("dut0_outs", {9'b0, level0, tone0, pv0, period0}, {9'b0, e});
                end
                if (q1.size() == 0) begin
                    check("dut1_unexpected_accept", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    check("dut1_outs", {9'b0, level1, tone1, pv1, 16'b0, period1}, {9'b0, e});
                end
            end else if (!reset) begin
                check("idle_no_pulse", {30'b0, pv1, pv0}, 32'b0);
            end
        end
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // Full-scale 8-sample square, continuous ready.
        sq(4, 4, 5, 1'b0, 1'b0);
        // Alternating samples: period 2.
        sq(1, 1, 6, 1'b0, 1'b0);
        // In-band noise and exact +/-HYST samples must not move the level.
        sq(4, 4, 5, 1'b1, 1'b0);
        // Lock at 8, then hold high long enough to saturate the 4-bit counter.
        sq(4, 4, 3, 1'b0, 1'b0);
        repeat (20) drive(24'h7FFFFF, 1'b1, 1'b1);
        sq(4, 4, 3, 1'b0, 1'b0);

        // Ready toggling every other cycle and a 10-cycle enable drop mid-wave.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                drive(24'h123456, 1'b0, 1'b1);
                drive(i < 4 ? 24'h7FFFFF : 24'h800000, 1'b1, 1'b1);
                if (r == 1 && i == 2) begin
                    for (int k = 0; k < 10; k++) drive(24'h800000, k[0], 1'b0);
                end
            end
        end

        // Reset mid-period with enable high; next edge only re-arms.
        sq(4, 2, 1, 1'b0, 1'b0);
        do_reset(1'b1);
        sq(4, 4, 3, 1'b0, 1'b0);

        // Randomized squares with noise and acceptance gaps.
        for (int k = 0; k < 15; k++) begin
            sq($urandom_range(1, 7), $urandom_range(1, 7), $urandom_range(2, 3),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        drive(24'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
